// File: rtl/axi_lite_imem_responder.sv
// AXI-lite read-only instruction memory responder with programmable latency and a preload port.
// Optional macro IMEM_RANDOM_DELAY_EN adds 0..7 LFSR-driven extra wait cycles per read.
module axi_lite_imem_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LAT        = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    input  logic [31:0]           saxi_araddr,
    input  logic                  saxi_arvalid,
    output logic                  saxi_arready,
    output logic                  saxi_rvalid,
    input  logic                  saxi_rready,
    output logic [31:0]           saxi_rdata,
    output logic [1:0]            saxi_rresp,
    output logic                  rd_done
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [31:0] SPAN  = 32'd4 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state, state_nxt;
    logic [4:0]              cnt, cnt_load;
    logic [31:0]             addr, resp_addr, offset;
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    resp_entry, decerr, slverr;
    logic [31:0]             mem [DEPTH];

`ifdef IMEM_RANDOM_DELAY_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign cnt_load = 5'(LAT) + {2'b00, lfsr[2:0]};
`else
    assign cnt_load = 5'(LAT);
`endif

    always_comb begin
        state_nxt  = state;
        resp_entry = 1'b0;
        resp_addr  = addr;
        case (state)
            IDLE: begin
                if (saxi_arvalid) begin
                    // zero total wait: decode straight from the bus address
                    resp_addr = saxi_araddr;
                    if (cnt_load == 5'd0) begin
                        state_nxt  = RESP;
                        resp_entry = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 5'd1) begin
                    state_nxt  = RESP;
                    resp_entry = 1'b1;
                end
            end
            RESP:    if (saxi_rready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign offset = resp_addr - BASE_ADDR;
    assign idx    = offset[DEPTH_LOG2+1:2];
    assign decerr = (offset >= SPAN);
    assign slverr = (resp_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= '0;
            cnt        <= '0;
            saxi_rdata <= '0;
            saxi_rresp <= 2'b00;
        end else begin
            if (state == IDLE && saxi_arvalid) begin
                addr <= saxi_araddr;
                cnt  <= cnt_load;
            end else if (state == WAIT) begin
                cnt <= cnt - 5'd1;
            end
            // mem is sampled before this edge's load write lands: read-before-write
            if (resp_entry) begin
                if (decerr) begin
                    saxi_rresp <= 2'b11;
                    saxi_rdata <= '0;
                end else if (slverr) begin
                    saxi_rresp <= 2'b10;
                    saxi_rdata <= '0;
                end else begin
                    saxi_rresp <= 2'b00;
                    saxi_rdata <= mem[idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    assign saxi_arready = (state == IDLE);
    assign saxi_rvalid  = (state == RESP);
    assign rd_done      = saxi_rvalid & saxi_rready;

endmodule

// File: tb/tb_axi_lite_imem_responder.sv
// Self-checking bench for axi_lite_imem_responder: transaction-level model plus directed literal checks.
// Build with IMEM_RANDOM_DELAY_EN defined to exercise the randomised latency mode.
module tb_axi_lite_imem_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int unsigned DL2  = 12;
    localparam int unsigned LATV = 3;

    logic            clk = 1'b0;
    logic            rst, ld_en, arvalid, rready;
    logic [DL2-1:0]  ld_addr;
    logic [31:0]     ld_data, araddr;
    logic            arready, rvalid, rd_done;
    logic [31:0]     rdata;
    logic [1:0]      rresp;

    int n_chk  = 0;
    int n_fail = 0;

    axi_lite_imem_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .LAT(LATV)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .saxi_araddr(araddr), .saxi_arvalid(arvalid), .saxi_arready(arready),
        .saxi_rvalid(rvalid), .saxi_rready(rready), .saxi_rdata(rdata),
        .saxi_rresp(rresp), .rd_done(rd_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input int unsigned i);
        return 32'h5A00_0000 ^ (i * 32'h0001_0203);
    endfunction

    // Transaction-level model: one outstanding read, due a fixed number of cycles after acceptance.
    logic [31:0] mm [4096];
    longint      cyc = 0, m_due = 0;
    bit          started = 0, m_busy = 0, m_valid = 0;
    logic [31:0] m_addr = '0, m_data = '0;
    logic [1:0]  m_resp = 2'b00;
    logic [15:0] m_lfsr = 16'hACE1;

    always @(posedge clk) begin
        int unsigned extra;
        logic [31:0] off;
`ifdef IMEM_RANDOM_DELAY_EN
        extra = int'(m_lfsr[2:0]);
`else
        extra = 0;
`endif
        if (rst) begin
            m_busy = 0; m_valid = 0; m_data = '0; m_resp = 2'b00; m_lfsr = 16'hACE1;
        end else begin
            if (m_valid && rready) begin
                m_valid = 0; m_busy = 0;
            end else if (!m_busy && arvalid) begin
                m_busy = 1; m_addr = araddr; m_due = cyc + 1 + LATV + extra;
            end
            if (m_busy && !m_valid && m_due == cyc + 1) begin
                off = m_addr - BASE;
                if (off >= 32'h4000)         begin m_resp = 2'b11; m_data = '0; end
                else if (m_addr[1:0] != 2'b0) begin m_resp = 2'b10; m_data = '0; end
                else                          begin m_resp = 2'b00; m_data = mm[off[13:2]]; end
                m_valid = 1;
            end
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
        if (ld_en) mm[ld_addr] = ld_data;
        cyc++;
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_arready", {31'b0, arready}, {31'b0, !m_busy});
            chk("m_rvalid",  {31'b0, rvalid},  {31'b0, m_valid});
            chk("m_rdata",   rdata,            m_data);
            chk("m_rresp",   {30'b0, rresp},   {30'b0, m_resp});
            chk("m_rd_done", {31'b0, rd_done}, {31'b0, m_valid && rready});
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_read(input string nm, input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        int n = 0;
        int lat = 0;
        araddr = a; arvalid = 1; rready = 1;
        @(negedge clk);
        while (!arready && n < 50) begin @(negedge clk); n++; end
        chk({nm, "_arready_seen"}, {31'b0, arready}, 32'd1);
        step();
        arvalid = 0;
        @(negedge clk);
        while (!rvalid && lat < 60) begin lat++; @(negedge clk); end
        chk({nm, "_rvalid_seen"}, {31'b0, rvalid}, 32'd1);
        chk({nm, "_rdata"}, rdata, ed);
        chk({nm, "_rresp"}, {30'b0, rresp}, {30'b0, er});
`ifdef IMEM_RANDOM_DELAY_EN
        chk({nm, "_lat_in_range"}, {31'b0, (lat >= int'(LATV) && lat <= int'(LATV) + 7)}, 32'd1);
`else
        chk({nm, "_latency"}, 32'(lat), 32'(LATV));
`endif
        step();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; ld_en = 0; ld_addr = '0; ld_data = '0; araddr = '0; arvalid = 0; rready = 0;
        step(); step();
        @(negedge clk);
        chk("rst_arready", {31'b0, arready}, 32'd1);
        chk("rst_rvalid",  {31'b0, rvalid},  32'd0);
        chk("rst_rdata",   rdata,            32'd0);
        chk("rst_rresp",   {30'b0, rresp},   32'd0);
        step();
        rst = 0;
        for (int i = 0; i < 4096; i++) begin
            ld_en = 1; ld_addr = DL2'(i); ld_data = pat(i);
            step();
        end
        ld_addr = '0; ld_data = 32'h0000_0413; step();
        ld_addr = 1;  ld_data = 32'h0000_9117; step();
        ld_en = 0;
        step();

`ifndef IMEM_RANDOM_DELAY_EN
        // Back-to-back reads with arvalid held: cycle T is the first handshake.
        arvalid = 1; araddr = BASE; rready = 1;
        @(negedge clk); chk("t_arready_T", {31'b0, arready}, 32'd1);
        step(); araddr = BASE + 32'd4;
        @(negedge clk); chk("t_arready_T1", {31'b0, arready}, 32'd0);
        step(); step(); step();
        @(negedge clk);
        chk("t_rvalid_T4",  {31'b0, rvalid},  32'd1);
        chk("t_rdata_T4",   rdata,            32'h0000_0413);
        chk("t_rresp_T4",   {30'b0, rresp},   32'd0);
        chk("t_rd_done_T4", {31'b0, rd_done}, 32'd1);
        step();
        @(negedge clk);
        chk("t_arready_T5", {31'b0, arready}, 32'd1);
        chk("t_rvalid_T5",  {31'b0, rvalid},  32'd0);
        step(); arvalid = 0;
        step(); step();
        @(negedge clk); chk("t_rvalid_T8", {31'b0, rvalid}, 32'd0);
        step();
        @(negedge clk);
        chk("t_rvalid_T9", {31'b0, rvalid}, 32'd1);
        chk("t_rdata_T9",  rdata,           32'h0000_9117);
        step();

        // rready held low for five cycles of rvalid.
        arvalid = 1; araddr = BASE + 32'd4; rready = 0;
        step(); arvalid = 0;
        step(); step(); step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_rvalid",  {31'b0, rvalid},  32'd1);
            chk("hold_rdata",   rdata,            32'h0000_9117);
            chk("hold_rd_done", {31'b0, rd_done}, 32'd0);
            step();
        end
        rready = 1;
        @(negedge clk); chk("hold_release_rd_done", {31'b0, rd_done}, 32'd1);
        step();
        @(negedge clk); chk("hold_after_rvalid", {31'b0, rvalid}, 32'd0);
        step();
`endif

        do_read("decerr_top",   32'h8000_4000, 32'd0, 2'b11);
        do_read("decerr_wrap",  32'h7FFF_FFFC, 32'd0, 2'b11);
        do_read("slverr",       32'h8000_0002, 32'd0, 2'b10);
        do_read("last_word",    32'h8000_3FFC, pat(4095), 2'b00);
        do_read("word1",        32'h8000_0004, 32'h0000_9117, 2'b00);

`ifndef IMEM_RANDOM_DELAY_EN
        // Reset while waiting drops the pending response.
        arvalid = 1; araddr = BASE; rready = 1;
        step(); arvalid = 0;
        step(); rst = 1;
        step(); rst = 0;
        @(negedge clk);
        chk("rstwait_arready", {31'b0, arready}, 32'd1);
        chk("rstwait_rvalid",  {31'b0, rvalid},  32'd0);
        repeat (5) begin
            step();
            @(negedge clk); chk("rstwait_no_resp", {31'b0, rvalid}, 32'd0);
        end
        step();
        do_read("after_rst", 32'h8000_0004, 32'h0000_9117, 2'b00);

        // Load write on the RESP-entry edge returns the old word.
        arvalid = 1; araddr = BASE; rready = 1;
        step(); arvalid = 0;
        step();
        step(); ld_en = 1; ld_addr = '0; ld_data = 32'hDEAD_BEEF;
        step(); ld_en = 0;
        @(negedge clk);
        chk("rbw_old_rdata", rdata, 32'h0000_0413);
        step();
        do_read("rbw_new", BASE, 32'hDEAD_BEEF, 2'b00);
`else
        for (int i = 0; i < 100; i++) begin
            do_read("rand", BASE + 32'(4 * (2 + (i % 16))), pat(2 + (i % 16)), 2'b00);
        end
`endif

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_imem_responder.md
Name: axi_lite_imem_responder

Overview:
- AXI-lite read-only responder (slave) for instruction memory; it is the memory-side end of the fetch unit's AR/R handshake.
- Accepts one read address at a time, waits a programmable number of cycles to model memory latency, then returns one 32-bit word with a response code.
- Backed by an internal word array. A separate load port preloads the array from the testbench/loader.

Parameters:
- BASE_ADDR, 32'h80000000, byte address mapped to word 0.
- DEPTH_LOG2, 12, log2 of the word count (4096 words = 16 KiB).
- LAT, 3, fixed wait cycles between AR handshake and R-valid (0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ld_en  in  1  load-port write enable.
- ld_addr  in  DEPTH_LOG2  word index for load write.
- ld_data  in  32  load-port write data.
- saxi_araddr  in  32  read byte address.
- saxi_arvalid  in  1  address valid from initiator.
- saxi_arready  out  1  responder can accept an address.
- saxi_rvalid  out  1  read data valid.
- saxi_rready  in  1  initiator accepts data.
- saxi_rdata  out  32  read word.
- saxi_rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- rd_done  out  1  high in the R handshake cycle (rvalid & rready); combinational.

Behaviour:
- Single clock, synchronous active-high reset. All state is updated on posedge clk.
- Reset values: state=IDLE, saxi_arready=1, saxi_rvalid=0, saxi_rdata=0, saxi_rresp=00, wait counter=0. Array contents are not reset.
- saxi_arready and saxi_rvalid are registered and decoded from state: arready=1 only in IDLE, rvalid=1 only in RESP.
- IDLE:
  - If arvalid & arready at edge T: latch araddr; counter<=LAT.
  - Next state is WAIT if LAT>0, otherwise RESP.
  - If arvalid is low, stay in IDLE.
- WAIT:
  - Counter decrements each cycle.
  - At the edge where counter==1, go to RESP.
  - arvalid is ignored; arready=0.
- Entry to RESP:
  - Compute offset = addr - BASE_ADDR (32-bit wrap arithmetic).
  - offset >= 4<<DEPTH_LOG2: rresp=11, rdata=0.
  - Else if addr[1:0]!=0: rresp=10, rdata=0.
  - Else: rresp=00, rdata=mem[offset[DEPTH_LOG2+1:2]].
  - DECERR takes priority over SLVERR.
- RESP:
  - rvalid, rdata and rresp are held stable until rready.
  - On rvalid & rready: return to IDLE; arready=1 next cycle; rvalid=0 next cycle; rdata and rresp keep their last values.
- Latency:
  - rvalid is first high in cycle T+1+LAT, where T is the AR handshake cycle.
  - With rready tied high, the next address can be accepted at T+2+LAT.
- Outstanding reads: at most one. No address buffering and no read-data skid.
- Load port:
  - ld_en writes mem[ld_addr]<=ld_data at posedge, legal in any state.
  - A write at the same edge as RESP entry to the same word returns the OLD data (read-before-write).
  - A write at any earlier edge is visible.
- Address wrap: araddr below BASE_ADDR wraps to a huge offset and gives DECERR.
- Reset mid-operation: at any state, rst forces IDLE with reset values next cycle. Any pending response is dropped.
- rready high while rvalid is low has no effect. arvalid dropping before handshake leaves the block in IDLE.

Optional Feature:
- Macro: IMEM_RANDOM_DELAY_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - On an AR handshake, counter<=LAT+lfsr[2:0], giving 0..7 extra wait cycles.
  - If that sum is 0, go straight to RESP.
  - Timing check becomes: rvalid in cycle T+1+LAT+lfsr[2:0], using the LFSR value sampled at T.
- When undefined: no LFSR logic; latency is exactly LAT.

Test Plan:
- Preload mem[0]=32'h00000413, mem[1]=32'h00009117; LAT=3; AR 0x80000000 at T, rready high → arready low at T+1; rvalid=1 with rdata=32'h00000413, rresp=00 at T+4; rd_done=1 at T+4; arready=1 at T+5.
- Back-to-back reads 0x80000000 then 0x80000004 with arvalid held high → second AR accepted at T+5; rdata=32'h00009117 at T+9.
- Hold rready low for 5 cycles after rvalid → rvalid, rdata, rresp stable all 5 cycles; single rd_done pulse on release; only one response returned.
- araddr=0x80004000 (just past 16 KiB) → rresp=11, rdata=0. araddr=0x7FFFFFFC → rresp=11. araddr=0x80000002 → rresp=10.
- Assert rst in WAIT (T+2) → rvalid stays 0, arready=1 at the cycle after rst; a fresh AR then completes normally.
- ld_en to word 0 with 32'hDEADBEEF on the RESP-entry edge of a read of word 0 → returns old value; a repeat read returns 32'hDEADBEEF. With IMEM_RANDOM_DELAY_EN, 100 reads all return correct data with latency within LAT..LAT+7.
